// File: rtl/booth_host_pkg.sv
// Shared types and default sizing for the Booth multiplier host sequencer.
package booth_host_pkg;

    localparam int unsigned DEF_W          = 5;
    localparam int unsigned DEF_TIMEOUT    = 64;
    localparam int unsigned DEF_RST_CYCLES = 2;

    typedef enum logic [2:0] {
        RESET_M,
        IDLE,
        START,
        SEND_A,
        SEND_B,
        WAIT_DONE,
        CAP_LO,
        RESP
    } state_e;

    // Counter must reach max(TIMEOUT, RST_CYCLES) - 1.
    function automatic int unsigned timer_width(input int unsigned timeout,
                                                input int unsigned rst_cycles);
        int unsigned m;
        m = (timeout > rst_cycles) ? timeout : rst_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int unsigned DEF_TMR_W = timer_width(DEF_TIMEOUT, DEF_RST_CYCLES);

endpackage

// File: rtl/booth_host_timer.sv
// Clear/enable counter with terminal-count compare, shared by the reset hold and done timeout.
module booth_host_timer #(
    parameter int unsigned TW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] tc_val,
    output logic [TW-1:0] count,
    output logic          tc
);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == tc_val);

endmodule

// File: rtl/booth_mult_host.sv
// Host sequencer for the serial Booth multiplier: operand load, done wait with timeout,
// two-beat result capture and automatic multiplier reset after power-up or timeout.
module booth_mult_host
    import booth_host_pkg::*;
#(
    parameter int unsigned W          = DEF_W,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           op_valid,
    output logic           op_ready,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_product,
    output logic           res_err,
    output logic           mult_start,
    output logic           mult_rst,
    output logic [W-1:0]   mult_data_in,
    input  logic [W-1:0]   mult_data_out,
    input  logic           mult_done
);

    localparam int unsigned TW = timer_width(TIMEOUT, RST_CYCLES);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   hi_q, hi_d;
    logic [2*W-1:0] res_product_q, res_product_d;
    logic           res_err_q, res_err_d;
    logic           res_valid_q, res_valid_d;
    logic           op_ready_q, op_ready_d;
    logic           mult_start_q, mult_start_d;
    logic           mult_rst_q, mult_rst_d;
    logic [W-1:0]   mult_data_in_q, mult_data_in_d;

    logic           tmr_clr;
    logic           tmr_en;
    logic           tmr_tc;
    logic [TW-1:0]  tmr_tc_val;
    logic [TW-1:0]  tmr_count;

    assign tmr_tc_val = (state_q == RESET_M) ? TW'(RST_CYCLES - 1) : TW'(TIMEOUT - 1);

    booth_host_timer #(
        .TW(TW)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .tc_val (tmr_tc_val),
        .count  (tmr_count),
        .tc     (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        hi_d          = hi_q;
        res_product_d = res_product_q;
        res_err_d     = res_err_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        case (state_q)
            RESET_M: begin
                tmr_en = 1'b1;
                if (tmr_tc) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (op_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    state_d = START;
                end
            end
            START:  state_d = SEND_A;
            SEND_A: state_d = SEND_B;
            SEND_B: begin
                tmr_clr = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // done takes priority over a timeout expiring in the same cycle
                if (mult_done) begin
                    hi_d    = mult_data_out;
                    state_d = CAP_LO;
                end else if (tmr_tc) begin
                    res_err_d     = 1'b1;
                    res_product_d = '0;
                    state_d       = RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CAP_LO: begin
                res_product_d = {hi_q, mult_data_out};
                state_d       = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    res_err_d = 1'b0;
                    tmr_clr   = 1'b1;
                    state_d   = res_err_q ? RESET_M : IDLE;
                end
            end
        endcase

        // Outputs are registered copies decoded from the next state.
        op_ready_d     = (state_d == IDLE);
        mult_start_d   = (state_d == START);
        mult_rst_d     = (state_d == RESET_M);
        res_valid_d    = (state_d == RESP);
        mult_data_in_d = '0;
        if (state_d == SEND_A) begin
            mult_data_in_d = a_q;
        end else if (state_d == SEND_B) begin
            mult_data_in_d = b_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RESET_M;
            a_q            <= '0;
            b_q            <= '0;
            hi_q           <= '0;
            res_product_q  <= '0;
            res_err_q      <= 1'b0;
            res_valid_q    <= 1'b0;
            op_ready_q     <= 1'b0;
            mult_start_q   <= 1'b0;
            mult_rst_q     <= 1'b1;
            mult_data_in_q <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            hi_q           <= hi_d;
            res_product_q  <= res_product_d;
            res_err_q      <= res_err_d;
            res_valid_q    <= res_valid_d;
            op_ready_q     <= op_ready_d;
            mult_start_q   <= mult_start_d;
            mult_rst_q     <= mult_rst_d;
            mult_data_in_q <= mult_data_in_d;
        end
    end

    assign op_ready     = op_ready_q;
    assign res_valid    = res_valid_q;
    assign res_product  = res_product_q;
    assign res_err      = res_err_q;
    assign mult_start   = mult_start_q;
    assign mult_rst     = mult_rst_q;
    assign mult_data_in = mult_data_in_q;

endmodule

// File: tb/tb_booth_mult_host.sv
// Directed bench for booth_mult_host; the bench itself plays the multiplier's serial side.
module tb_booth_mult_host;

    localparam int unsigned W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           op_valid;
    logic           op_ready;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_product;
    logic           res_err;
    logic           mult_start;
    logic           mult_rst;
    logic [W-1:0]   mult_data_in;
    logic [W-1:0]   mult_data_out;
    logic           mult_done;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    booth_mult_host #(
        .W          (W),
        .TIMEOUT    (64),
        .RST_CYCLES (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_a          (op_a),
        .op_b          (op_b),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_product   (res_product),
        .res_err       (res_err),
        .mult_start    (mult_start),
        .mult_rst      (mult_rst),
        .mult_data_in  (mult_data_in),
        .mult_data_out (mult_data_out),
        .mult_done     (mult_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Accept one operand pair from IDLE and follow it into WAIT_DONE.
    task automatic load_op(input logic [W-1:0] a, input logic [W-1:0] b);
        chk("idle_ready", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        step();
        op_valid = 1'b0;
        chk("start_pulse", 32'(mult_start), 32'd1);
        chk("start_busy", 32'(op_ready), 32'd0);
        chk("start_data0", 32'(mult_data_in), 32'd0);
        step();
        chk("start_once", 32'(mult_start), 32'd0);
        chk("send_a", 32'(mult_data_in), 32'(a));
        step();
        chk("send_b", 32'(mult_data_in), 32'(b));
        step();
        chk("wait_data0", 32'(mult_data_in), 32'd0);
        chk("wait_no_valid", 32'(res_valid), 32'd0);
    endtask

    // Return done with the high word, then the low word, and check the response.
    task automatic finish_op(input logic [W-1:0] hi, input logic [W-1:0] lo,
                             input logic [2*W-1:0] prod);
        mult_done     = 1'b1;
        mult_data_out = hi;
        step();
        chk("caplo_no_valid", 32'(res_valid), 32'd0);
        mult_done     = 1'b0;
        mult_data_out = lo;
        step();
        mult_data_out = '0;
        chk("resp_valid", 32'(res_valid), 32'd1);
        chk("resp_product", 32'(res_product), 32'(prod));
        chk("resp_err", 32'(res_err), 32'd0);
    endtask

    task automatic retire_ok();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("retire_valid", 32'(res_valid), 32'd0);
        chk("retire_ready", 32'(op_ready), 32'd1);
        chk("retire_rst", 32'(mult_rst), 32'd0);
    endtask

    initial begin
        rst           = 1'b0;
        op_valid      = 1'b0;
        op_a          = '0;
        op_b          = '0;
        res_ready     = 1'b0;
        mult_data_out = '0;
        mult_done     = 1'b0;

        // 1: reset values, then mult_rst held for two cycles after release
        step();
        step();
        chk("rst_mult_rst", 32'(mult_rst), 32'd1);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_product", 32'(res_product), 32'd0);
        chk("rst_err", 32'(res_err), 32'd0);
        chk("rst_start", 32'(mult_start), 32'd0);
        chk("rst_data_in", 32'(mult_data_in), 32'd0);
        rst = 1'b1;
        step();
        chk("hold1_mult_rst", 32'(mult_rst), 32'd1);
        chk("hold1_op_ready", 32'(op_ready), 32'd0);
        step();
        chk("hold_end_mult_rst", 32'(mult_rst), 32'd0);
        chk("hold_end_op_ready", 32'(op_ready), 32'd1);
        chk("hold_end_valid", 32'(res_valid), 32'd0);

        // 2: 3 * 5 = 15
        load_op(5'd3, 5'd5);
        finish_op(5'b00000, 5'b01111, 10'd15);
        retire_ok();

        // 3 + 5: -3 * 4 = -12, response held while res_ready stays low
        load_op(5'b11101, 5'd4);
        finish_op(5'b11111, 5'b10100, 10'b1111110100);
        for (int i = 0; i < 10; i++) begin
            op_valid = ((i % 2) == 0);
            op_a     = 5'd9;
            op_b     = 5'd9;
            step();
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_product", 32'(res_product), 32'h3F4);
            chk("hold_busy", 32'(op_ready), 32'd0);
        end
        op_valid = 1'b0;
        retire_ok();
        step();
        chk("no_queued_start", 32'(mult_start), 32'd0);
        chk("still_idle", 32'(op_ready), 32'd1);

        // 4: done never arrives -> timeout after 64 WAIT_DONE cycles
        load_op(5'd7, 5'd2);
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd64);
        chk("timeout_err", 32'(res_err), 32'd1);
        chk("timeout_product", 32'(res_product), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("to_rst1", 32'(mult_rst), 32'd1);
        chk("to_valid_low", 32'(res_valid), 32'd0);
        chk("to_err_clear", 32'(res_err), 32'd0);
        chk("to_busy", 32'(op_ready), 32'd0);
        step();
        chk("to_rst2", 32'(mult_rst), 32'd1);
        step();
        chk("to_rst_end", 32'(mult_rst), 32'd0);
        chk("to_ready", 32'(op_ready), 32'd1);

        // 6: reset during WAIT_DONE, spurious done afterwards
        load_op(5'd9, 5'd6);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("mid_rst_mult_rst", 32'(mult_rst), 32'd1);
        chk("mid_rst_ready", 32'(op_ready), 32'd0);
        chk("mid_rst_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_start", 32'(mult_start), 32'd0);
        chk("mid_rst_data_in", 32'(mult_data_in), 32'd0);
        chk("mid_rst_product", 32'(res_product), 32'd0);
        step();
        rst           = 1'b1;
        mult_done     = 1'b1;
        mult_data_out = 5'h1F;
        step();
        chk("re_hold1", 32'(mult_rst), 32'd1);
        chk("re_hold1_valid", 32'(res_valid), 32'd0);
        step();
        chk("re_hold_end", 32'(mult_rst), 32'd0);
        chk("re_ready", 32'(op_ready), 32'd1);
        step();
        step();
        chk("spur_valid", 32'(res_valid), 32'd0);
        chk("spur_ready", 32'(op_ready), 32'd1);
        chk("spur_start", 32'(mult_start), 32'd0);
        mult_done     = 1'b0;
        mult_data_out = '0;
        load_op(5'd1, 5'd2);
        finish_op(5'b00010, 5'b00001, 10'h041);
        retire_ok();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/booth_mult_host.md
Name: booth_mult_host

Overview:
- Host-side sequencer that drives the serial port of the Booth multiplier: start pulse, two-beat operand load, done wait, two-beat result capture.
- Sits between a parallel valid/ready operand source and the multiplier.
- Adds done timeout, error reporting and automatic multiplier reset.
- Treats operands and product as opaque two's-complement bit patterns; no arithmetic in this block.

Parameters:
- W, 5: multiplier serial word width; operands W bits, product 2W bits.
- TIMEOUT, 64: maximum WAIT_DONE cycles before error.
- RST_CYCLES, 2: cycles mult_rst is held high after reset and after a timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  host idle; operands accepted on op_valid&&op_ready.
- op_a  in  W  multiplicand.
- op_b  in  W  multiplier.
- res_valid  out  1  result valid; held until res_ready.
- res_ready  in  1  consumer accepts result.
- res_product  out  2W  {hi,lo} product, 0 on error.
- res_err  out  1  timeout flag, qualified by res_valid.
- mult_start  out  1  one-cycle start pulse to the multiplier.
- mult_rst  out  1  active-high reset to the multiplier.
- mult_data_in  out  W  serial operand bus to the multiplier.
- mult_data_out  in  W  serial result bus from the multiplier.
- mult_done  in  1  multiplier done, high in the high-word beat.

Behaviour:
- Reset (rst=0, async):
  - State goes to RESET_M.
  - op_ready=0, res_valid=0, res_product=0, res_err=0.
  - mult_start=0, mult_data_in=0, mult_rst=1.
  - Timer and operand registers are cleared.
  - Reset mid-operation aborts everything; no result is produced.
- RESET_M: mult_rst=1 for RST_CYCLES cycles, then IDLE.
- IDLE:
  - op_ready=1.
  - On op_valid, latch op_a and op_b, then go to START.
  - op_ready=0 in every other state; op_valid is ignored while busy.
- START: mult_start=1 for exactly one cycle, mult_data_in=0, then SEND_A.
- SEND_A: mult_data_in=a for one cycle, then SEND_B.
- SEND_B: mult_data_in=b for one cycle, then WAIT_DONE.
- WAIT_DONE:
  - mult_data_in=0; the timer clears on entry and increments each cycle.
  - If mult_done=1, register hi=mult_data_out and go to CAP_LO.
  - Else if timer==TIMEOUT-1, set res_err=1, res_product=0 and go to RESP.
  - If done and the timeout expire in the same cycle, done wins.
- CAP_LO: register lo=mult_data_out; the mult_done level is don't-care; go to RESP.
- RESP:
  - res_valid=1; res_product={hi,lo} (or 0 on error) stays stable until res_ready.
  - On res_ready, res_valid falls the next cycle.
  - Next state is IDLE, or RESET_M if res_err. res_err clears when leaving RESP.
  - res_ready high in the first RESP cycle completes in that cycle.
- mult_done outside WAIT_DONE is ignored; a spurious done cannot corrupt hi/lo.
- Latency:
  - Acceptance edge E.
  - mult_start high in cycle E+1.
  - Operand a in E+2, operand b in E+3.
  - WAIT_DONE from E+4.
  - res_valid rises 2 cycles after the done cycle.
- Throughput: one operation in flight; no overlap.
- All outputs are registered.

Decomposition:
- Package booth_host_pkg:
  - state enum {RESET_M, IDLE, START, SEND_A, SEND_B, WAIT_DONE, CAP_LO, RESP}.
  - Default W, TIMEOUT and RST_CYCLES constants.
  - Timer width constant, $clog2 of the larger of TIMEOUT and RST_CYCLES.
- Sub-module booth_host_timer: clear/enable/terminal-count counter, shared by RESET_M hold and WAIT_DONE timeout. The FSM and datapath stay in the top level.

Test Plan:
1. Release rst, hold op_valid=0 -> mult_rst high exactly 2 cycles, then op_ready=1; all other outputs 0.
2. Multiply a=3, b=5; model returns done with hi=00000, then lo=01111 -> mult_start pulse 1 cycle; mult_data_in 3 then 5; res_product=10'd15, res_err=0.
3. Multiply a=5'b11101 (-3), b=4; model returns hi=11111, lo=10100 -> res_product=10'b1111110100 (-12).
4. Model never asserts done -> after 64 WAIT_DONE cycles res_valid=1, res_err=1, res_product=0; after res_ready, mult_rst high 2 cycles, then op_ready=1.
5. Hold res_ready=0 for 10 cycles after res_valid -> res_valid and res_product stable; op_valid pulses meanwhile are ignored (op_ready=0).
6. Pulse rst low during WAIT_DONE, with a spurious mult_done in IDLE afterwards -> immediate reset values, no res_valid, RESET_M sequence repeats; spurious done is ignored.
